// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} one quotient bit per cycle; outputs are registered.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_FREE    = 2'b00;
  localparam logic [1:0] ST_BY_ZERO = 2'b01;
  localparam logic [1:0] ST_ON      = 2'b10;
  localparam logic [1:0] ST_END     = 2'b11;

  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
  localparam logic [2*DATA_W-1:0] ZERO_2W  = {(2*DATA_W){1'b0}};

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   dvd_r;
  logic [DATA_W-1:0]   dsr_r;
  logic                sign_a_r;
  logic                sign_b_r;
  logic                signed_r;
  logic [2*DATA_W-1:0] res_r;

  logic [DATA_W:0]     shift_s;
  logic [DATA_W+1:0]   trial_s;
  logic [DATA_W-1:0]   rem_next_s;
  logic                qbit_s;
  logic                neg_quot_s;
  logic                neg_rem_s;
  logic [DATA_W-1:0]   quot_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;
  logic [DATA_W-1:0]   abs_a_s;
  logic [DATA_W-1:0]   abs_b_s;

  // Restoring step, operand magnitudes and final sign correction.
  always_comb begin
    shift_s    = {rem_r, dvd_r[DATA_W-1]};
    // Extra guard bit: the shifted partial remainder can reach 2*divisor-1.
    trial_s    = {1'b0, shift_s} - {2'b00, dsr_r};
    rem_next_s = ZERO_W;
    qbit_s     = 1'b0;
    if (trial_s[DATA_W+1]) begin
      rem_next_s = shift_s[DATA_W-1:0];
      qbit_s     = 1'b0;
    end else begin
      rem_next_s = trial_s[DATA_W-1:0];
      qbit_s     = 1'b1;
    end

    neg_quot_s = signed_r & (sign_a_r ^ sign_b_r);
    neg_rem_s  = signed_r & sign_a_r;
    quot_fix_s = dvd_r;
    rem_fix_s  = rem_r;
    if (neg_quot_s) begin
      quot_fix_s = -dvd_r;
    end else begin
      quot_fix_s = dvd_r;
    end
    if (neg_rem_s) begin
      rem_fix_s = -rem_r;
    end else begin
      rem_fix_s = rem_r;
    end

    abs_a_s = opdata1_i;
    abs_b_s = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) begin
      abs_a_s = -opdata1_i;
    end else begin
      abs_a_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[DATA_W-1]) begin
      abs_b_s = -opdata2_i;
    end else begin
      abs_b_s = opdata2_i;
    end
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_FREE;
      cnt_r    <= CNT_ZERO;
      rem_r    <= ZERO_W;
      dvd_r    <= ZERO_W;
      dsr_r    <= ZERO_W;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      signed_r <= 1'b0;
      res_r    <= ZERO_2W;
      result_o <= ZERO_2W;
      ready_o  <= 1'b0;
    end else begin
      case (state_r)
        ST_FREE: begin
          ready_o  <= 1'b0;
          result_o <= ZERO_2W;
          if (start_i && !annul_i) begin
            if (opdata2_i == ZERO_W) begin
              state_r <= ST_BY_ZERO;
            end else begin
              rem_r    <= ZERO_W;
              dvd_r    <= abs_a_s;
              dsr_r    <= abs_b_s;
              sign_a_r <= opdata1_i[DATA_W-1];
              sign_b_r <= opdata2_i[DATA_W-1];
              signed_r <= signed_div_i;
              cnt_r    <= CNT_ZERO;
              state_r  <= ST_ON;
            end
          end else begin
            state_r <= ST_FREE;
          end
        end
        ST_BY_ZERO: begin
          if (annul_i) begin
            state_r <= ST_FREE;
          end else begin
            res_r   <= ZERO_2W;
            state_r <= ST_END;
          end
        end
        ST_ON: begin
          if (annul_i) begin
            state_r <= ST_FREE;
          end else if (cnt_r != CNT_LAST) begin
            rem_r <= rem_next_s;
            dvd_r <= {dvd_r[DATA_W-2:0], qbit_s};
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            res_r   <= {rem_fix_s, quot_fix_s};
            state_r <= ST_END;
          end
        end
        ST_END: begin
          // EX holds start_i until it has seen ready_o; its drop releases the divider.
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= res_r;
          end else begin
            ready_o  <= 1'b0;
            result_o <= ZERO_2W;
            state_r  <= ST_FREE;
          end
        end
        default: begin
          state_r <= ST_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomised checks of div_iter against hand-computed values and a reference model.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int tests_run;
  int tests_failed;

  div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Runs one division with start held, checks latency, result, hold in END and release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 100);
    check({tag, "_lat"}, 64'(n - 1), 64'(exp_lat));
    check({tag, "_res"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {result[62:0], ready}, {exp[62:0], 1'b1});
    @(negedge clk);
    start = 1'b0;
    op1 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check({tag, "_drop"}, {result, 63'd0, ready} >> 64, 64'd0);
    check({tag, "_drop_rdy"}, {63'd0, ready}, 64'd0);
    check({tag, "_drop_res"}, result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          seen;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", {63'd0, ready}, 64'd0);
    check("reset_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
    do_div("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 34);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34);
    do_div("divu_zero", 1'b0, 32'd55, 32'd0, 64'd0, 2);
    do_div("div_zero", 1'b1, 32'hFFFF_FFF0, 32'd0, 64'd0, 2);

    // Annul in the middle of ON: no result ever appears.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    check("annul_on_no_ready", 64'(seen), 64'd0);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Annul during BY_ZERO, and annul blocking acceptance in FREE.
    @(negedge clk);
    op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    check("annul_free_no_ready", 64'(seen), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    @(negedge clk);

    // Synchronous reset mid-division.
    @(negedge clk);
    signed_div = 1'b1; op1 = 32'd12345; op2 = 32'd17; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_rdy", {63'd0, ready}, 64'd0);
    check("rst_mid_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    check("rst_mid_no_ready", 64'(seen), 64'd0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 1000));
      rs = i[0] ^ i[1];
      do_div($sformatf("rand%0d", i), rs, ra, rb, ref_div(rs, ra, rb), (rb == 32'd0) ? 2 : 34);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
